pinwheel_ram_arbiter: RTL and testbench

PINWHEEL_RAM_ARBITER -- requirements
Module: pinwheel_ram_arbiter

---
 rtl/pinwheel_ram_arbiter.sv | 142 ++++++++++++++
 tb/tb_pinwheel_ram_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pinwheel_ram_arbiter.sv
// Purpose: three-port round-robin arbiter in front of a single-port-style RAM, with optional per-port lock and idle timeout.
// Latency: grant is combinational in the request cycle; resp_valid/resp_rdata follow one cycle later.
// Backpressure: a port waits while req_ready is low; a lock owner blocks the other ports until it releases or times out.
module pinwheel_ram_arbiter #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              req_valid,
  input  logic [2:0]              req_write,
  input  logic [2:0]              req_lock,
  input  logic [3*ADDR_WIDTH-1:0] req_addr,
  input  logic [3*DATA_WIDTH-1:0] req_wdata,
  output logic [2:0]              req_ready,
  output logic [2:0]              resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic [ADDR_WIDTH-1:0]   ram_raddr,
  output logic [ADDR_WIDTH-1:0]   ram_waddr,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  output logic                    ram_wren,
  input  logic [DATA_WIDTH-1:0]   ram_rdata
);

  localparam int CW = (LOCK_TIMEOUT < 2) ? 1 : $clog2(LOCK_TIMEOUT + 1);
  // The release edge is the one on which the idle count would reach LOCK_TIMEOUT.
  localparam logic [CW-1:0] IDLE_LAST = CW'(LOCK_TIMEOUT - 1);

  typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

  lock_state_t   state;
  logic [1:0]    ptr;
  logic [1:0]    owner;
  logic [CW-1:0] idle_cnt;

  logic [2:0]            grant;
  logic [1:0]            win;
  logic                  found;
  logic [1:0]            cand;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Pick the winner: only the owner while locked, otherwise first valid port from ptr upward.
  always_comb begin
    grant = 3'b000;
    win   = ptr;
    found = 1'b0;
    cand  = ptr;
    if (!rst) begin
      if (state == LOCKED) begin
        win = owner;
        if (req_valid[owner]) begin
          found = 1'b1;
        end
      end else begin
        for (int k = 0; k < 3; k++) begin
          if (!found && req_valid[cand]) begin
            found = 1'b1;
            win   = cand;
          end
          cand = nxt(cand);
        end
      end
      if (found) begin
        grant[win] = 1'b1;
      end
    end
  end

  // Steer the winner's address and write data onto the RAM pins.
  always_comb begin
    case (win)
      2'd1: begin
        sel_addr  = req_addr[ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[DATA_WIDTH +: DATA_WIDTH];
      end
      2'd2: begin
        sel_addr  = req_addr[2*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[2*DATA_WIDTH +: DATA_WIDTH];
      end
      default: begin
        sel_addr  = req_addr[0 +: ADDR_WIDTH];
        sel_wdata = req_wdata[0 +: DATA_WIDTH];
      end
    endcase
  end

  assign req_ready  = grant;
  assign ram_raddr  = sel_addr;
  assign ram_waddr  = sel_addr;
  assign ram_wdata  = sel_wdata;
  assign ram_wren   = |(grant & req_write);
  // The RAM has one cycle of read latency, so its output lines up with resp_valid.
  assign resp_rdata = ram_rdata;

  // Lock FSM, round-robin pointer, idle timer and the one-cycle response flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= UNLOCKED;
      owner      <= 2'd0;
      ptr        <= 2'd0;
      idle_cnt   <= '0;
      resp_valid <= 3'b000;
    end else begin
      resp_valid <= grant;
      case (state)
        UNLOCKED: begin
          if (found) begin
            ptr      <= nxt(win);
            idle_cnt <= '0;
            if (req_lock[win]) begin
              state <= LOCKED;
              owner <= win;
            end
          end
        end
        LOCKED: begin
          if (found) begin
            idle_cnt <= '0;
            if (!req_lock[owner]) begin
              state <= UNLOCKED;
              ptr   <= nxt(owner);
            end
          end else if (idle_cnt == IDLE_LAST) begin
            state    <= UNLOCKED;
            ptr      <= nxt(owner);
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: state <= UNLOCKED;
      endcase
    end
  end

endmodule

// File: tb/tb_pinwheel_ram_arbiter.sv
// Bench for pinwheel_ram_arbiter: directed scenarios plus random traffic against a reference model.
// The RAM behind the arbiter is a 2-state array with one cycle of read latency.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_pinwheel_ram_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int LT = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      req_valid, req_write, req_lock;
  logic [3*AW-1:0] req_addr;
  logic [3*DW-1:0] req_wdata;
  logic [2:0]      req_ready, resp_valid;
  logic [DW-1:0]   resp_rdata;
  logic [AW-1:0]   ram_raddr, ram_waddr;
  logic [DW-1:0]   ram_wdata, ram_rdata;
  logic            ram_wren;

  always #5 clk = ~clk;

  pinwheel_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .ram_raddr(ram_raddr), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_wren(ram_wren), .ram_rdata(ram_rdata)
  );

  // Behavioural RAM behind the arbiter.
  bit [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_wren) ram[ram_waddr] <= ram_wdata;
    ram_rdata <= ram[ram_raddr];
  end

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int          m_ptr = 0;
  int          m_owner = -1;
  int          m_idle = 0;
  bit [DW-1:0] m_mem [0:(1<<AW)-1];
  logic [2:0]  m_resp = 3'b000;
  logic        m_resp_rd = 1'b0;
  logic [DW-1:0] m_rdata = '0;

  logic [2:0]    last_ready, last_resp;
  logic          last_wren;
  logic [DW-1:0] last_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
    int p;
    if (rst) return -1;
    if (m_owner >= 0) return req_valid[m_owner] ? m_owner : -1;
    for (int k = 0; k < 3; k++) begin
      p = (m_ptr + k) % 3;
      if (req_valid[p]) return p;
    end
    return -1;
  endfunction

  task automatic cycle();
    int         g;
    logic [2:0] er;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    a = '0;
    d = '0;
    g = pick();
    er = (g >= 0) ? 3'(1 << g) : 3'b000;
    if (g >= 0) begin
      a = req_addr[g*AW +: AW];
      d = req_wdata[g*DW +: DW];
    end
    @(negedge clk);
    last_ready = req_ready;
    last_resp  = resp_valid;
    last_wren  = ram_wren;
    last_rdata = resp_rdata;
    chk("ready", req_ready, er);
    chk("wren", ram_wren, (g >= 0) ? req_write[g] : 1'b0);
    if (g >= 0) begin
      chk("raddr", ram_raddr, a);
      chk("waddr", ram_waddr, a);
      if (req_write[g]) chk("wdata", ram_wdata, d);
    end
    chk("resp_valid", resp_valid, rst ? 3'b000 : m_resp);
    if (!rst && m_resp != 3'b000 && m_resp_rd) chk("rdata", resp_rdata, m_rdata);
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_owner = -1; m_idle = 0; m_resp = 3'b000; m_resp_rd = 1'b0;
    end else begin
      m_resp    = er;
      m_resp_rd = (g >= 0) && !req_write[g];
      if (g >= 0) begin
        if (req_write[g]) m_mem[a] = d;
        else m_rdata = m_mem[a];
        m_idle = 0;
        if (m_owner < 0) begin
          m_ptr = (g + 1) % 3;
          if (req_lock[g]) m_owner = g;
        end else if (!req_lock[g]) begin
          m_owner = -1;
          m_ptr = (g + 1) % 3;
        end
      end else if (m_owner >= 0) begin
        m_idle++;
        if (m_idle == LT) begin
          m_ptr = (m_owner + 1) % 3;
          m_owner = -1;
          m_idle = 0;
        end
      end
    end
    #1;
  endtask

  task automatic set_port(input int p, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_write[p] = wr;
    req_addr[p*AW +: AW] = a;
    req_wdata[p*DW +: DW] = d;
  endtask

  initial begin
    logic [2:0] seq_rdy [0:3];
    logic [2:0] seq_rsp [0:3];
    int n, wren_cnt;
    bit seen;

    rst = 1'b1;
    req_valid = 3'b111; req_write = 3'b000; req_lock = 3'b000;
    req_addr = '0; req_wdata = '0;
    #1;
    // Reset holds everything quiet even with all ports requesting.
    cycle();
    chk("rst_ready", last_ready, 3'b000);
    chk("rst_resp", last_resp, 3'b000);
    chk("rst_wren", last_wren, 1'b0);
    cycle();
    rst = 1'b0;

    // Three ports contend for reads: round-robin from port 0.
    req_valid = 3'b111;
    set_port(0, 1'b0, 10'd1, '0);
    set_port(1, 1'b0, 10'd2, '0);
    set_port(2, 1'b0, 10'd3, '0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) req_valid = 3'b000;
      cycle();
      seq_rdy[i] = last_ready;
      seq_rsp[i] = last_resp;
    end
    chk("rr_grant0", seq_rdy[0], 3'b001);
    chk("rr_grant1", seq_rdy[1], 3'b010);
    chk("rr_grant2", seq_rdy[2], 3'b100);
    chk("rr_resp0", seq_rsp[1], 3'b001);
    chk("rr_resp1", seq_rsp[2], 3'b010);
    chk("rr_resp2", seq_rsp[3], 3'b100);

    // Write then read-back of the top address.
    wren_cnt = 0;
    req_valid = 3'b010;
    set_port(1, 1'b1, 10'h3FF, 32'hDEADBEEF);
    cycle(); wren_cnt += int'(last_wren);
    req_valid = 3'b001;
    set_port(0, 1'b0, 10'h3FF, '0);
    cycle(); wren_cnt += int'(last_wren);
    req_valid = 3'b000;
    cycle(); wren_cnt += int'(last_wren);
    chk("wr_pulse_count", wren_cnt, 1);
    chk("rd_resp_port", last_resp, 3'b001);
    chk("rd_after_wr", last_rdata, 32'hDEADBEEF);

    // Port 2 locks for four accesses while ports 0 and 1 keep asking.
    req_valid = 3'b010;
    set_port(1, 1'b0, 10'd7, '0);
    cycle();
    req_valid = 3'b111; req_lock = 3'b100;
    set_port(2, 1'b1, 10'd20, 32'h1111_0000);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) req_lock = 3'b000;
      req_wdata[2*DW +: DW] = 32'h1111_0000 + i;
      cycle();
      if (last_ready != 3'b100) n++;
    end
    chk("lock_exclusive", n, 0);
    cycle();
    chk("lock_next_port0", last_ready, 3'b001);

    // Port 1 locks, then goes idle until the timeout frees the arbiter.
    req_valid = 3'b111; req_lock = 3'b010;
    cycle();
    chk("lock1_taken", last_ready, 3'b010);
    req_valid = 3'b101; req_lock = 3'b000;
    n = 0; seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      cycle();
      if (last_ready[2]) seen = 1'b1;
      else n++;
    end
    chk("timeout_idle_cycles", n, LT);
    chk("timeout_winner", last_ready, 3'b100);

    // Random traffic over a small address window.
    for (int i = 0; i < 400; i++) begin
      req_valid = 3'($urandom);
      for (int p = 0; p < 3; p++) begin
        set_port(p, 1'($urandom), AW'($urandom_range(7)), DW'($urandom));
        req_lock[p] = ($urandom_range(3) == 0);
      end
      cycle();
    end

    // Reset landing on the response cycle of a read drops that response.
    rst = 1'b1; req_valid = 3'b000; req_lock = 3'b000;
    cycle();
    rst = 1'b0;
    req_valid = 3'b001;
    set_port(0, 1'b0, 10'd5, '0);
    cycle();
    chk("pre_rst_grant", last_ready, 3'b001);
    rst = 1'b1; req_valid = 3'b000;
    cycle();
    chk("inflight_dropped", last_resp, 3'b000);
    cycle();
    rst = 1'b0;
    cycle();
    chk("no_resp_after_rst", last_resp, 3'b000);
    req_valid = 3'b111; req_write = 3'b000;
    cycle();
    chk("post_rst_port0", last_ready, 3'b001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
